fp32_sqrt: RTL and testbench
============================

Name: fp32_sqrt

Overview:
IEEE-754 single-precision square-root unit for the FPU datapath. It accepts one operand under a simple ready/valid handshake and computes the root iteratively with a radix-2 restoring digit recurrence, one bit per cycle. The integer-root core is internal, 25-bit radicand class. The result is rounded per the rounding mode, and special operands are handled per IEEE-754.

Parameters:
None. The internal root datapath is fixed: 26 root bits, being 24 significand bits plus guard and round, with sticky taken from the remainder.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- ready  input  1  request: start an operation when the unit is idle
- rounding_mode  input  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes are treated as RNE
- a  input  32  IEEE-754 binary32 operand
- y  output  32  IEEE-754 binary32 result; held stable from valid until the next capture
- valid  output  1  one-cycle pulse: y is valid

Behaviour:
- One clock, synchronous active-high reset: rst=1 at a rising edge forces state IDLE, valid=0, y=0x00000000, and clears all internal registers. Reset mid-operation aborts the operation and produces no valid pulse.
- FSM states: IDLE, CALC, ROUND, DONE.
  - IDLE: if ready=1 at an edge, latch a and rounding_mode, go to CALC. Otherwise stay.
  - CALC: 26 cycles, one root bit per cycle. Then go to ROUND.
  - ROUND: apply rounding and special-case override, register y. Then go to DONE.
  - DONE: valid=1 for exactly one cycle. Then go to IDLE.
- Latency is fixed for every input, including specials: valid goes high 28 cycles after the capturing edge.
- ready and a are sampled only in IDLE; changes to them during CALC, ROUND or DONE are ignored. With ready held high, back-to-back operations occur.
  - a is sampled at the edge that leaves DONE plus one, i.e. the first IDLE edge.
  - Valid therefore pulses once every 29 cycles, with at least one low cycle between pulses.
- Normal path (positive, normal operand, exponent field E, fraction f):
  - Unbiased exponent e = E-127.
  - If e is odd: radicand = {1,f} shifted left 1, and e is decremented by 1.
  - Result exponent = e/2 + 127. It is always in the normal range, so no overflow or underflow can occur.
  - The radicand (1.f in [1,4)) feeds the restoring recurrence: trial subtract (4R + next two radicand bits) − (4Q+1); keep the result if it is non-negative and set q=1.
  - The root lies in [1,2): 24 significand bits, then guard bit G, round bit R, and sticky S = (remainder != 0) OR R.
- Rounding: the result sign is always +, so:
  - RNE: round up if G and (S or lsb).
  - RTZ and RDN: truncate.
  - RUP: round up if G or S.
  - RMM: round up if G.
  - If a round-up carries out of the significand, it increments the exponent (cannot overflow).
- Special cases:
  - NaN in (any payload, either sign) → 0x7FC00000.
  - Negative nonzero input, including −inf and negative denormals, → 0x7FC00000.
  - +0 → 0x00000000; −0 → 0x80000000.
  - +inf → 0x7F800000.
  - Positive denormal inputs are flushed to zero → 0x00000000.
- No exception flag outputs.

Test Plan:
- Reset, then hold ready=1. Apply a=0x40800000 (4.0) → valid pulses 28 cycles after capture, y=0x40000000. Then apply a=0x41100000 (9.0) → y=0x40400000. Apply a=0x3F800000 (1.0) → y=0x3F800000.
- Rounding on an odd exponent: a=0x40000000 (2.0) with RNE → y=0x3FB504F3. With RUP → y=0x3FB504F4. With RTZ → y=0x3FB504F3.
- Specials:
  - 0xBF800000 → 0x7FC00000
  - 0x7FC12345 → 0x7FC00000
  - 0x7F800000 → 0x7F800000
  - 0x80000000 → 0x80000000
  - 0x00000001 → 0x00000000
  - Each special must still take 28 cycles.
- Handshake streaming: hold ready=1 and change a 5 ns after each valid rising edge, through 1000 random positive normals. Check that every valid is a single-cycle pulse and that the results are bit-exact against a reference sqrtf in RNE.
- Ready low: with ready=0 the unit stays IDLE and valid=0 indefinitely. Raising ready captures a on the next edge.
- Reset mid-operation: assert rst for 1 cycle at CALC cycle 10 → y=0, valid=0, no pulse for the aborted op. The next operation runs normally.

Source files
------------

// File: rtl/fp32_sqrt.sv
// rtl/fp32_sqrt.sv - IEEE-754 binary32 square root, radix-2 restoring recurrence
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-high
//   ready         start request, sampled only while idle
//   rounding_mode 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE
//   a             binary32 operand
//   y             binary32 result, stable from valid until the next capture
//   valid         one-cycle pulse, 28 cycles after the capturing edge
module fp32_sqrt (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [2:0]  rounding_mode,
  input  logic [31:0] a,
  output logic [31:0] y,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t      state;
  logic [31:0] a_q;
  logic [2:0]  rm_q;
  logic [51:0] rad_q;   // radicand, consumed two bits per cycle from the top
  logic [25:0] root_q;  // 1 integer bit, 23 fraction bits, guard, round
  logic [26:0] rem_q;   // partial remainder, bounded by 2*root
  logic [4:0]  cnt_q;

  // Recurrence step: trial = 4R + next two radicand bits, subtrahend = 4Q + 1
  logic [28:0] trial;
  logic [28:0] sub;
  logic        keep;
  logic [26:0] rem_next;

  assign trial    = {rem_q, rad_q[51:50]};
  assign sub      = {1'b0, root_q, 2'b01};
  assign keep     = (trial >= sub);
  // The kept remainder always fits 27 bits, so modular low-bit subtraction suffices.
  assign rem_next = keep ? (trial[26:0] - sub[26:0]) : trial[26:0];

  // Radicand load: an odd biased exponent means an even unbiased exponent,
  // so 1.f is used as-is; otherwise 1.f is doubled. Either way the value is
  // scaled to 50 fraction bits so that 26 root bits come out.
  logic [23:0] mant_in;
  logic [51:0] rad_load;

  assign mant_in  = {1'b1, a[22:0]};
  assign rad_load = a[23] ? {1'b0, mant_in, 27'd0} : {mant_in, 28'd0};

  // Rounding and special-case selection, evaluated in ROUND
  logic        guard_bit;
  logic        sticky_bit;
  logic        lsb_bit;
  logic        round_up;
  logic [7:0]  exp_base;
  logic [31:0] norm_res;
  logic        e_all1;
  logic        e_zero;
  logic        f_nz;
  logic [31:0] result;

  always_comb begin
    guard_bit  = root_q[1];
    sticky_bit = root_q[0] | (|rem_q);
    lsb_bit    = root_q[2];

    case (rm_q)
      3'b001, 3'b010: round_up = 1'b0;
      3'b011:         round_up = guard_bit | sticky_bit;
      3'b100:         round_up = guard_bit;
      default:        round_up = guard_bit & (sticky_bit | lsb_bit);
    endcase

    // (E + 127) >> 1, written as E[7:1] + 63 + E[0] to stay within 8 bits
    exp_base = {1'b0, a_q[30:24]} + 8'd63 + {7'd0, a_q[23]};

    // The hidden bit root_q[25] lands in the exponent LSB, hence exp_base - 1.
    // A rounding carry out of the fraction ripples into the exponent as well.
    norm_res = {1'b0, exp_base - 8'd1, 23'd0} + {8'd0, root_q[25:2]}
             + {31'd0, round_up};

    e_all1 = &a_q[30:23];
    e_zero = ~|a_q[30:23];
    f_nz   = |a_q[22:0];

    if (e_all1 && f_nz) begin
      result = 32'h7FC0_0000;
    end else if (a_q[31]) begin
      result = (e_zero && !f_nz) ? 32'h8000_0000 : 32'h7FC0_0000;
    end else if (e_zero) begin
      result = 32'h0000_0000;  // +0 and flushed positive denormals
    end else if (e_all1) begin
      result = 32'h7F80_0000;
    end else begin
      result = norm_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= 32'd0;
      rm_q   <= 3'd0;
      rad_q  <= 52'd0;
      root_q <= 26'd0;
      rem_q  <= 27'd0;
      cnt_q  <= 5'd0;
      y      <= 32'd0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            a_q    <= a;
            rm_q   <= rounding_mode;
            rad_q  <= rad_load;
            root_q <= 26'd0;
            rem_q  <= 27'd0;
            cnt_q  <= 5'd0;
            state  <= CALC;
          end
        end
        CALC: begin
          rem_q  <= rem_next;
          root_q <= {root_q[24:0], keep};
          rad_q  <= {rad_q[49:0], 2'b00};
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd25) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          y     <= result;
          state <= DONE;
        end
        DONE: begin
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_sqrt.sv
// tb/tb_fp32_sqrt.sv - directed and streaming checks for fp32_sqrt
module tb_fp32_sqrt;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [2:0]  rounding_mode;
  logic [31:0] a;
  logic [31:0] y;
  logic        valid;

  int checks = 0;
  int errors = 0;

  fp32_sqrt dut (
    .clk           (clk),
    .rst           (rst),
    .ready         (ready),
    .rounding_mode (rounding_mode),
    .a             (a),
    .y             (y),
    .valid         (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Correctly rounded (RNE) root of a positive normal, via binary-search isqrt
  function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
    longint unsigned m, target, lo, hi, mid, s;
    logic [8:0] es;
    m = {40'd0, 1'b1, x[22:0]};
    if (!x[23]) m = m * 2;
    target = m << 25;
    lo = 0;
    hi = 64'd1 << 26;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= target) lo = mid;
      else hi = mid;
    end
    s  = (lo + 1) >> 1;
    es = {1'b0, x[30:23]} + 9'd127;
    return {1'b0, es[8:1], 23'd0} + s[31:0] - 32'h0080_0000;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] val, input logic [2:0] rm,
                        input logic [31:0] exp_y);
    int lat;
    lat = 0;
    @(negedge clk);
    a = val;
    rounding_mode = rm;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    a = 32'hDEAD_BEEF;
    rounding_mode = 3'b011;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, lat, 28);
    check(tag, y, exp_y);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, valid}, 32'd0);
  endtask

  function automatic logic [31:0] rand_normal();
    logic [7:0]  e;
    logic [22:0] f;
    e = 8'($urandom_range(1, 254));
    f = 23'($urandom);
    return {1'b0, e, f};
  endfunction

  initial begin
    int vcount;
    int got;
    logic [31:0] a_cur;
    logic [31:0] y_hold;

    rst = 1'b1;
    ready = 1'b0;
    rounding_mode = 3'd0;
    a = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_y", y, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("sqrt4",    32'h4080_0000, 3'b000, 32'h4000_0000);
    run_op("sqrt9",    32'h4110_0000, 3'b000, 32'h4040_0000);
    run_op("sqrt1",    32'h3F80_0000, 3'b000, 32'h3F80_0000);
    run_op("sqrt0p25", 32'h3E80_0000, 3'b000, 32'h3F00_0000);
    run_op("minnorm",  32'h0080_0000, 3'b000, 32'h2000_0000);
    run_op("sqrt2_rne", 32'h4000_0000, 3'b000, 32'h3FB5_04F3);
    run_op("sqrt2_rup", 32'h4000_0000, 3'b011, 32'h3FB5_04F4);
    run_op("sqrt2_rtz", 32'h4000_0000, 3'b001, 32'h3FB5_04F3);
    run_op("sqrt2_rdn", 32'h4000_0000, 3'b010, 32'h3FB5_04F3);
    run_op("sqrt2_rmm", 32'h4000_0000, 3'b100, 32'h3FB5_04F3);
    run_op("sqrt2_rm7", 32'h4000_0000, 3'b111, 32'h3FB5_04F3);
    run_op("max_rne",  32'h7F7F_FFFF, 3'b000, 32'h5F7F_FFFF);
    run_op("max_rup",  32'h7F7F_FFFF, 3'b011, 32'h5F80_0000);
    run_op("max_rmm",  32'h7F7F_FFFF, 3'b100, 32'h5F7F_FFFF);

    run_op("neg_one",  32'hBF80_0000, 3'b000, 32'h7FC0_0000);
    run_op("nan_pay",  32'h7FC1_2345, 3'b000, 32'h7FC0_0000);
    run_op("neg_nan",  32'hFFC0_0000, 3'b000, 32'h7FC0_0000);
    run_op("pos_inf",  32'h7F80_0000, 3'b000, 32'h7F80_0000);
    run_op("neg_inf",  32'hFF80_0000, 3'b000, 32'h7FC0_0000);
    run_op("neg_zero", 32'h8000_0000, 3'b000, 32'h8000_0000);
    run_op("pos_zero", 32'h0000_0000, 3'b000, 32'h0000_0000);
    run_op("pos_den",  32'h0000_0001, 3'b000, 32'h0000_0000);
    run_op("neg_den",  32'h8000_0001, 3'b000, 32'h7FC0_0000);

    // Ready low: nothing starts, y holds
    y_hold = y;
    vcount = 0;
    ready = 1'b0;
    a = 32'h4080_0000;
    repeat (60) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("idle_no_valid", vcount, 0);
    check("idle_y_hold", y, y_hold);
    run_op("after_idle", 32'h4110_0000, 3'b000, 32'h4040_0000);

    // Reset during CALC cycle 10
    @(negedge clk);
    a = 32'h4110_0000;
    rounding_mode = 3'd0;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_y", y, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("abort_no_pulse", vcount, 0);
    run_op("after_abort", 32'h4080_0000, 3'b000, 32'h4000_0000);

    // Streaming with ready held high; a changes 5 ns after each valid edge
    @(negedge clk);
    rounding_mode = 3'd0;
    a_cur = rand_normal();
    a = a_cur;
    ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      got = 0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (valid) begin
          got = n;
          break;
        end
      end
      check("stream_gap", got, (i == 0) ? 29 : 28);
      check("stream_y", y, ref_sqrt(a_cur));
      a_cur = rand_normal();
      a = a_cur;
      if (i == 999) ready = 1'b0;
      @(negedge clk);
      check("stream_pulse", {31'd0, valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
